// File: rtl/mole_round_sequencer_pkg.sv
// Shared types, defaults and LFSR helper for the whack-a-mole round sequencer.
package mole_round_sequencer_pkg;

  localparam int DEF_CNT_W    = 28;
  localparam int DEF_PTS_W    = 6;
  localparam int DEF_N_LIGHTS = 9;
  localparam int IDX_W        = 4;

  localparam logic [7:0]       DEF_SEED  = 8'hA5;
  localparam logic [7:0]       LFSR_TAPS = 8'hB8;  // x^8+x^6+x^5+x^4+1
  localparam logic [IDX_W-1:0] IDX_NONE  = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GAP    = 3'd1,
    ST_PICK   = 3'd2,
    ST_LIT    = 3'd3,
    ST_RESULT = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  function automatic logic [7:0] lfsr_next(input logic [7:0] value);
    return {value[6:0], ^(value & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mole_round_sequencer_picker.sv
// 8-bit LFSR light picker: offers lfsr[3:0] as a candidate and flags whether it
// is a legal light that differs from the previously lit one.
module mole_round_sequencer_picker
  import mole_round_sequencer_pkg::*;
#(
  parameter logic [7:0] SEED     = DEF_SEED,
  parameter int         N_LIGHTS = DEF_N_LIGHTS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [7:0]       load_value,
  input  logic             advance,
  input  logic [IDX_W-1:0] prev_idx,
  output logic [IDX_W-1:0] candidate,
  output logic             accept
);

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(N_LIGHTS - 1);

  logic [7:0] lfsr_r;

  // LFSR state: a seed load wins over advancing; a zero seed falls back to SEED.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_r <= SEED;
    end else if (load) begin
      lfsr_r <= (load_value == 8'h00) ? SEED : load_value;
    end else if (advance) begin
      lfsr_r <= lfsr_next(lfsr_r);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign candidate = lfsr_r[IDX_W-1:0];
  assign accept    = (candidate <= MAX_IDX) && (candidate != prev_idx);

endmodule

// File: rtl/mole_round_sequencer.sv
// Whack-a-mole round sequencer: gap, pick a light, hold it for the on-window,
// score a matching hit or record a miss, repeat until the round budget is spent.
module mole_round_sequencer
  import mole_round_sequencer_pkg::*;
#(
  parameter int         CNT_W    = DEF_CNT_W,
  parameter int         PTS_W    = DEF_PTS_W,
  parameter int         N_LIGHTS = DEF_N_LIGHTS,
  parameter logic [7:0] SEED     = DEF_SEED
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                seed_load,
  input  logic [7:0]          seed_in,
  input  logic                start,
  input  logic [CNT_W-1:0]    light_on,
  input  logic [CNT_W-1:0]    light_between,
  input  logic [PTS_W-1:0]    total_rounds,
  input  logic                deathmatch,
  input  logic                hit_valid,
  input  logic [IDX_W-1:0]    hit_index,
  output logic [N_LIGHTS-1:0] lights,
  output logic [PTS_W-1:0]    score,
  output logic [PTS_W-1:0]    misses,
  output logic [PTS_W-1:0]    rounds_left,
  output logic                busy,
  output logic                game_over
);

  localparam logic [CNT_W-1:0]    CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PTS_W-1:0]    PTS_ZERO  = {PTS_W{1'b0}};
  localparam logic [PTS_W-1:0]    PTS_ONE   = {{(PTS_W-1){1'b0}}, 1'b1};
  localparam logic [PTS_W-1:0]    PTS_MAX   = {PTS_W{1'b1}};
  localparam logic [N_LIGHTS-1:0] LIGHT_ONE = {{(N_LIGHTS-1){1'b0}}, 1'b1};

  state_e             state_r, state_nxt;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt;
  logic [CNT_W-1:0]   on_cfg_r, on_cfg_nxt;
  logic [CNT_W-1:0]   between_cfg_r, between_cfg_nxt;
  logic               dm_cfg_r, dm_cfg_nxt;
  logic [PTS_W-1:0]   score_r, score_nxt;
  logic [PTS_W-1:0]   misses_r, misses_nxt;
  logic [PTS_W-1:0]   rounds_left_r, rounds_left_nxt;
  logic [IDX_W-1:0]   prev_idx_r, prev_idx_nxt;
  logic               last_miss_r, last_miss_nxt;
  logic [N_LIGHTS-1:0] lights_r, lights_nxt;
  logic               busy_r, busy_nxt;
  logic               game_over_r, game_over_nxt;
  logic               advance_s;
  logic [IDX_W-1:0]   candidate_s;
  logic               accept_s;

  assign advance_s = (state_r == ST_PICK);

  mole_round_sequencer_picker #(
    .SEED     (SEED),
    .N_LIGHTS (N_LIGHTS)
  ) u_picker (
    .clk        (clk),
    .reset      (reset),
    .load       (seed_load),
    .load_value (seed_in),
    .advance    (advance_s),
    .prev_idx   (prev_idx_r),
    .candidate  (candidate_s),
    .accept     (accept_s)
  );

  // Next-state and datapath update; a start pulse overrides whatever state is active.
  always_comb begin
    state_nxt       = state_r;
    cnt_nxt         = cnt_r;
    on_cfg_nxt      = on_cfg_r;
    between_cfg_nxt = between_cfg_r;
    dm_cfg_nxt      = dm_cfg_r;
    score_nxt       = score_r;
    misses_nxt      = misses_r;
    rounds_left_nxt = rounds_left_r;
    prev_idx_nxt    = prev_idx_r;
    last_miss_nxt   = last_miss_r;
    if (start) begin
      on_cfg_nxt      = light_on;
      between_cfg_nxt = light_between;
      dm_cfg_nxt      = deathmatch;
      score_nxt       = PTS_ZERO;
      misses_nxt      = PTS_ZERO;
      rounds_left_nxt = total_rounds;
      cnt_nxt         = light_between;
      last_miss_nxt   = 1'b0;
      if (total_rounds == PTS_ZERO) begin
        state_nxt = ST_DONE;
      end else begin
        state_nxt = ST_GAP;
      end
    end else begin
      case (state_r)
        ST_IDLE: state_nxt = ST_IDLE;
        ST_GAP: begin
          if (cnt_r == CNT_ZERO) begin
            state_nxt = ST_PICK;
          end else begin
            cnt_nxt = cnt_r - CNT_ONE;
          end
        end
        ST_PICK: begin
          if (accept_s) begin
            prev_idx_nxt = candidate_s;
            cnt_nxt      = on_cfg_r;
            state_nxt    = ST_LIT;
          end else begin
            state_nxt = ST_PICK;
          end
        end
        ST_LIT: begin
          // A matching hit on the final window cycle still counts as a hit.
          if (hit_valid && (hit_index == prev_idx_r)) begin
            score_nxt     = (score_r != PTS_MAX) ? score_r + PTS_ONE : score_r;
            last_miss_nxt = 1'b0;
            state_nxt     = ST_RESULT;
          end else if (cnt_r == CNT_ZERO) begin
            misses_nxt    = (misses_r != PTS_MAX) ? misses_r + PTS_ONE : misses_r;
            last_miss_nxt = 1'b1;
            state_nxt     = ST_RESULT;
          end else begin
            cnt_nxt = cnt_r - CNT_ONE;
          end
        end
        ST_RESULT: begin
          rounds_left_nxt = (rounds_left_r != PTS_ZERO) ? rounds_left_r - PTS_ONE : PTS_ZERO;
          if ((rounds_left_r == PTS_ONE) || (dm_cfg_r && last_miss_r)) begin
            state_nxt = ST_DONE;
          end else begin
            cnt_nxt   = between_cfg_r;
            state_nxt = ST_GAP;
          end
        end
        ST_DONE: state_nxt = ST_DONE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output values for the coming cycle, derived from the next state so outputs stay registered.
  always_comb begin
    lights_nxt    = {N_LIGHTS{1'b0}};
    busy_nxt      = 1'b0;
    game_over_nxt = 1'b0;
    if (state_nxt == ST_LIT) begin
      lights_nxt = LIGHT_ONE << prev_idx_nxt;
    end else begin
      lights_nxt = {N_LIGHTS{1'b0}};
    end
    busy_nxt      = (state_nxt == ST_GAP) || (state_nxt == ST_PICK) ||
                    (state_nxt == ST_LIT) || (state_nxt == ST_RESULT);
    game_over_nxt = (state_nxt == ST_DONE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= CNT_ZERO;
      on_cfg_r      <= CNT_ZERO;
      between_cfg_r <= CNT_ZERO;
      dm_cfg_r      <= 1'b0;
      score_r       <= PTS_ZERO;
      misses_r      <= PTS_ZERO;
      rounds_left_r <= PTS_ZERO;
      prev_idx_r    <= IDX_NONE;
      last_miss_r   <= 1'b0;
      lights_r      <= {N_LIGHTS{1'b0}};
      busy_r        <= 1'b0;
      game_over_r   <= 1'b0;
    end else begin
      state_r       <= state_nxt;
      cnt_r         <= cnt_nxt;
      on_cfg_r      <= on_cfg_nxt;
      between_cfg_r <= between_cfg_nxt;
      dm_cfg_r      <= dm_cfg_nxt;
      score_r       <= score_nxt;
      misses_r      <= misses_nxt;
      rounds_left_r <= rounds_left_nxt;
      prev_idx_r    <= prev_idx_nxt;
      last_miss_r   <= last_miss_nxt;
      lights_r      <= lights_nxt;
      busy_r        <= busy_nxt;
      game_over_r   <= game_over_nxt;
    end
  end

  assign lights      = lights_r;
  assign score       = score_r;
  assign misses      = misses_r;
  assign rounds_left = rounds_left_r;
  assign busy        = busy_r;
  assign game_over   = game_over_r;

endmodule

// File: tb/tb_mole_round_sequencer.sv
// Scoreboard bench for mole_round_sequencer: stimulus queues expected light indices
// and end-of-game tallies; a monitor compares them as the DUT presents them.
module tb_mole_round_sequencer;

  localparam int CNT_W = 28;
  localparam int PTS_W = 6;

  logic             clk = 1'b0;
  logic             reset, seed_load, start, deathmatch, hit_valid;
  logic [7:0]       seed_in;
  logic [CNT_W-1:0] light_on, light_between;
  logic [PTS_W-1:0] total_rounds;
  logic [3:0]       hit_index;
  logic [8:0]       lights;
  logic [PTS_W-1:0] score, misses, rounds_left;
  logic             busy, game_over;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [PTS_W-1:0] score;
    logic [PTS_W-1:0] misses;
    logic [PTS_W-1:0] rounds_left;
  } end_t;

  logic [3:0] exp_idx_q[$];
  end_t       exp_end_q[$];
  logic [7:0] m_lfsr;
  logic [3:0] m_prev;

  always #5 clk = ~clk;

  mole_round_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .seed_load     (seed_load),
    .seed_in       (seed_in),
    .start         (start),
    .light_on      (light_on),
    .light_between (light_between),
    .total_rounds  (total_rounds),
    .deathmatch    (deathmatch),
    .hit_valid     (hit_valid),
    .hit_index     (hit_index),
    .lights        (lights),
    .score         (score),
    .misses        (misses),
    .rounds_left   (rounds_left),
    .busy          (busy),
    .game_over     (game_over)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference LFSR written straight from x^8+x^6+x^5+x^4+1.
  function automatic logic [7:0] m_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic model_pick(output logic [3:0] idx, output int cycles);
    logic [3:0] c;
    bit found;
    found = 1'b0;
    cycles = 0;
    idx = 4'hF;
    for (int n = 0; n < 300 && !found; n++) begin
      c = m_lfsr[3:0];
      cycles++;
      if (c <= 4'd8 && c != m_prev) begin
        found = 1'b1;
        idx = c;
        m_prev = c;
        exp_idx_q.push_back(c);
      end
      m_lfsr = m_step(m_lfsr);
    end
  endtask

  task automatic push_end(input int s, input int m, input int r);
    end_t e;
    e.score = PTS_W'(s);
    e.misses = PTS_W'(m);
    e.rounds_left = PTS_W'(r);
    exp_end_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game(input int between, input int on, input int rounds, input bit dm);
    light_between = CNT_W'(between);
    light_on = CNT_W'(on);
    total_rounds = PTS_W'(rounds);
    deathmatch = dm;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic hit(input logic [3:0] idx);
    hit_valid = 1'b1;
    hit_index = idx;
    tick();
    hit_valid = 1'b0;
  endtask

  task automatic pulse_seed(input logic [7:0] value);
    seed_in = value;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
  endtask

  // Call on a falling edge; k counts falling edges until a light shows.
  task automatic wait_lights(input int budget, output int k);
    k = 0;
    while (lights == 9'd0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (lights == 9'd0) begin
      checks++;
      errors++;
      $display("FAIL wait_lights: actual=timeout required=light within %0d cycles", budget);
    end
  endtask

  task automatic measure_lit(output int dur);
    dur = 0;
    while (lights != 9'd0 && dur < 100) begin
      dur++;
      @(negedge clk);
    end
  endtask

  task automatic wait_over(input int budget);
    int k;
    k = 0;
    while (!game_over && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!game_over) begin
      checks++;
      errors++;
      $display("FAIL wait_over: actual=timeout required=game_over within %0d cycles", budget);
    end
  endtask

  // Monitor: each new light is checked against the model, each game end against its tallies.
  initial begin : monitor
    logic [8:0] prev_l;
    logic [8:0] last_lit;
    logic       prev_go;
    logic [3:0] idx;
    end_t       e;
    prev_l = 9'd0;
    last_lit = 9'd0;
    prev_go = 1'b0;
    forever begin
      @(negedge clk);
      if (lights != 9'd0 && prev_l == 9'd0) begin
        if (exp_idx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL lit_unexpected: actual=%0h required=no light", lights);
        end else begin
          idx = exp_idx_q.pop_front();
          check("lit_index", 32'(lights), 32'(9'd1 << idx));
          check("lit_repeat", 32'(lights == last_lit), 32'd0);
        end
        last_lit = lights;
      end
      if (game_over && !prev_go) begin
        if (exp_end_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL game_over_unexpected: actual=1 required=0");
        end else begin
          e = exp_end_q.pop_front();
          check("end_score", 32'(score), 32'(e.score));
          check("end_misses", 32'(misses), 32'(e.misses));
          check("end_rounds_left", 32'(rounds_left), 32'(e.rounds_left));
          check("end_lights", 32'(lights), 32'd0);
        end
      end
      prev_l = lights;
      prev_go = game_over;
    end
  end

  initial begin : stimulus
    logic [3:0] i1, i2, wrong;
    int p1, p2, k, dur;
    reset = 1'b1;
    seed_load = 1'b0;
    seed_in = 8'h00;
    start = 1'b0;
    deathmatch = 1'b0;
    hit_valid = 1'b0;
    hit_index = 4'd0;
    light_on = CNT_W'(4);
    light_between = CNT_W'(3);
    total_rounds = PTS_W'(2);
    m_lfsr = 8'hA5;
    m_prev = 4'hF;
    tick();
    tick();
    // reset must override start and seed_load on the same cycle
    start = 1'b1;
    seed_load = 1'b1;
    seed_in = 8'h11;
    tick();
    reset = 1'b0;
    start = 1'b0;
    seed_load = 1'b0;
    repeat (10) tick();
    check("idle_lights", 32'(lights), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_game_over", 32'(game_over), 32'd0);
    check("idle_rounds_left", 32'(rounds_left), 32'd0);
    check("idle_score", 32'(score), 32'd0);
    check("idle_misses", 32'(misses), 32'd0);

    // zero-round game ends immediately
    push_end(0, 0, 0);
    start_game(3, 4, 0, 1'b0);
    check("zero_game_over", 32'(game_over), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    @(negedge clk);

    // two rounds, both hit two cycles after the light appears
    push_end(2, 0, 0);
    model_pick(i1, p1);
    model_pick(i2, p2);
    start_game(3, 4, 2, 1'b0);
    @(negedge clk);
    wait_lights(40, k);
    check("first_lit_delay", 32'(k), 32'(4 + p1));
    tick();
    tick();
    hit(i1);
    @(negedge clk);
    wait_lights(400, k);
    tick();
    tick();
    hit(i2);
    @(negedge clk);
    wait_over(50);

    // two rounds, no hits: each light lasts light_on+1 cycles
    push_end(0, 2, 0);
    model_pick(i1, p1);
    model_pick(i2, p2);
    start_game(3, 4, 2, 1'b0);
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      wait_lights(400, k);
      measure_lit(dur);
      check("lit_length", 32'(dur), 32'd5);
    end
    wait_over(50);

    // deathmatch: first miss ends the game
    push_end(0, 1, 4);
    model_pick(i1, p1);
    start_game(3, 4, 5, 1'b1);
    @(negedge clk);
    wait_over(400);
    repeat (20) @(negedge clk);
    check("dm_busy", 32'(busy), 32'd0);

    // wrong-index hit ignored, correct hit on the last window cycle scores
    pulse_seed(8'h3C);
    m_lfsr = 8'h3C;
    push_end(1, 0, 0);
    model_pick(i1, p1);
    wrong = (i1 == 4'd8) ? 4'd0 : i1 + 4'd1;
    start_game(3, 4, 1, 1'b0);
    light_on = CNT_W'(0);
    light_between = CNT_W'(0);
    total_rounds = PTS_W'(0);
    deathmatch = 1'b1;
    hit(i1);
    @(negedge clk);
    wait_lights(400, k);
    tick();
    hit(wrong);
    tick();
    tick();
    hit(i1);
    @(negedge clk);
    wait_over(50);

    // restart mid-LIT of round 2 with score 1
    model_pick(i1, p1);
    model_pick(i2, p2);
    start_game(3, 6, 3, 1'b0);
    @(negedge clk);
    wait_lights(400, k);
    tick();
    hit(i1);
    @(negedge clk);
    wait_lights(400, k);
    tick();
    check("pre_restart_score", 32'(score), 32'd1);
    push_end(0, 2, 0);
    model_pick(i1, p1);
    model_pick(i2, p2);
    start_game(2, 3, 2, 1'b0);
    check("restart_lights", 32'(lights), 32'd0);
    check("restart_score", 32'(score), 32'd0);
    check("restart_rounds_left", 32'(rounds_left), 32'd2);
    check("restart_busy", 32'(busy), 32'd1);
    @(negedge clk);
    wait_over(1000);

    // zero seed falls back to SEED; twenty rounds never repeat an index
    pulse_seed(8'h00);
    m_lfsr = 8'hA5;
    push_end(0, 20, 0);
    for (int r = 0; r < 20; r++) model_pick(i1, p1);
    start_game(0, 0, 20, 1'b0);
    @(negedge clk);
    wait_over(8000);

    repeat (5) @(negedge clk);
    check("idx_queue_drained", 32'(exp_idx_q.size()), 32'd0);
    check("end_queue_drained", 32'(exp_end_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
